// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard sequencer
package hazard_pkg;

  // Wait-state FSM for multi-cycle data-memory accesses
  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - forwarding source select for one execute-stage operand
module forward_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        fwd
);

  // Newest producer wins: memory stage ahead of writeback; x0 never forwards
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - stall/flush/forward control and memory wait-state FSM
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MAX_MEM_WAIT           = 8,
  parameter int STALL_CNT_WIDTH        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic                              ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemAccessM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemReqM_o,
  output logic                              MemErr_o,
  output logic [STALL_CNT_WIDTH-1:0]        StallCount_o
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_nxt;
  logic                mem_stall;
  logic                mem_req;
  logic                load_use;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  assign load_use = ResultSrcE_i && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  forward_unit #(.ADDR_W(REGISTER_ADDRESS_WIDTH)) u_fwd_a (
    .rs          (Rs1E_i),
    .rd_m        (RdM_i),
    .reg_write_m (RegWriteM_i),
    .rd_w        (RdW_i),
    .reg_write_w (RegWriteW_i),
    .fwd         (fwd_a)
  );

  forward_unit #(.ADDR_W(REGISTER_ADDRESS_WIDTH)) u_fwd_b (
    .rs          (Rs2E_i),
    .rd_m        (RdM_i),
    .reg_write_m (RegWriteM_i),
    .rd_w        (RdW_i),
    .reg_write_w (RegWriteW_i),
    .fwd         (fwd_b)
  );

  // State and wait counter advance on the falling edge, with the pipeline registers
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Wait-state next-state logic; the counter holds the index of the current MEM_WAIT cycle
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    mem_stall = 1'b0;
    mem_req   = 1'b0;
    case (state)
      RUN: begin
        mem_req = MemAccessM_i;
        if (MemAccessM_i && !MemReadyM_i) begin
          mem_stall = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (MemReadyM_i) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt == WAIT_W'(MAX_MEM_WAIT)) begin
            state_nxt = ERROR;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Pipeline enables: reset bubbles everything, a memory stall freezes all, else branch beats load-use
  always_comb begin
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    StallE_o    = 1'b0;
    StallM_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    FlushW_o    = 1'b0;
    MemReqM_o   = 1'b0;
    ForwardAE_o = FWD_RF;
    ForwardBE_o = FWD_RF;
    if (!rst_n) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      MemReqM_o   = mem_req;
      ForwardAE_o = fwd_a;
      ForwardBE_o = fwd_b;
      if (mem_stall) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end else if (PCSrcE_i) begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (load_use) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    end
  end

  assign MemErr_o = (state == ERROR);

  // Saturating count of cycles in which fetch was held
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount_o <= '0;
    end else if (StallF_o && (StallCount_o != '1)) begin
      StallCount_o <= StallCount_o + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

  localparam int AW    = 5;
  localparam int MAXW  = 8;
  localparam int CW    = 16;
  localparam int CW_S  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM;

  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReq, MemErr;
  logic [1:0] FwdA, FwdB;
  logic [CW-1:0] Count;
  logic StallF_s, StallD_s, StallE_s, StallM_s, FlushD_s, FlushE_s, FlushW_s, MemReq_s, MemErr_s;
  logic [1:0] FwdA_s, FwdB_s;
  logic [CW_S-1:0] Count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.REGISTER_ADDRESS_WIDTH(AW), .MAX_MEM_WAIT(MAXW), .STALL_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .RdM_i(RdM), .RegWriteM_i(RegWriteM),
    .RdW_i(RdW), .RegWriteW_i(RegWriteW), .MemAccessM_i(MemAccessM), .MemReadyM_i(MemReadyM),
    .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
    .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW), .ForwardAE_o(FwdA), .ForwardBE_o(FwdB),
    .MemReqM_o(MemReq), .MemErr_o(MemErr), .StallCount_o(Count)
  );

  hazard_sequencer #(.REGISTER_ADDRESS_WIDTH(AW), .MAX_MEM_WAIT(MAXW), .STALL_CNT_WIDTH(CW_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .RdM_i(RdM), .RegWriteM_i(RegWriteM),
    .RdW_i(RdW), .RegWriteW_i(RegWriteW), .MemAccessM_i(MemAccessM), .MemReadyM_i(MemReadyM),
    .StallF_o(StallF_s), .StallD_o(StallD_s), .StallE_o(StallE_s), .StallM_o(StallM_s),
    .FlushD_o(FlushD_s), .FlushE_o(FlushE_s), .FlushW_o(FlushW_s), .ForwardAE_o(FwdA_s), .ForwardBE_o(FwdB_s),
    .MemReqM_o(MemReq_s), .MemErr_o(MemErr_s), .StallCount_o(Count_s)
  );

  // ---------------- behavioural model ----------------
  int m_wait = 0;   // how many MEM_WAIT cycles have elapsed in the current access (0 = not waiting)
  bit m_err  = 0;
  int m_cnt  = 0;
  int m_cnt_s = 0;

  function automatic logic [1:0] fwd_model(logic [AW-1:0] rs, logic [AW-1:0] rdm, logic wem,
                                           logic [AW-1:0] rdw, logic wew);
    if (wem && rdm != 0 && rdm == rs) return 2'b10;
    if (wew && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_mem_stall();
    if (m_err) return 1;
    if (m_wait > 0) return !MemReadyM;
    return MemAccessM && !MemReadyM;
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemReq,FwdA,FwdB}
  function automatic logic [11:0] model_outs();
    bit sf, sd, se, sm, fd, fe, fw, mr, lu;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0; mr = 0;
    if (!rst_n) return 12'b0000_1110_0000;
    lu = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    mr = m_err ? 0 : (m_wait > 0 ? 1 : MemAccessM);
    if (model_mem_stall()) begin
      sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
    end else if (PCSrcE) begin
      fd = 1; fe = 1;
    end else if (lu) begin
      sf = 1; sd = 1; fe = 1;
    end
    return {sf, sd, se, sm, fd, fe, fw, mr,
            fwd_model(Rs1E, RdM, RegWriteM, RdW, RegWriteW),
            fwd_model(Rs2E, RdM, RegWriteM, RdW, RegWriteW)};
  endfunction

  always @(negedge clk or negedge rst_n) begin
    logic [11:0] v;
    if (!rst_n) begin
      m_wait = 0; m_err = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      v = model_outs();
      if (v[11]) begin
        if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        if (m_cnt_s < (1 << CW_S) - 1) m_cnt_s = m_cnt_s + 1;
      end
      if (!m_err) begin
        if (model_mem_stall()) begin
          if (m_wait == MAXW) m_err = 1;
          else m_wait = m_wait + 1;
        end else begin
          m_wait = 0;
        end
      end
    end
  end

  // Compare every cycle, mid-cycle (outputs have settled since the falling edge)
  always @(posedge clk) begin
    logic [11:0] e, a, a_s;
    e   = model_outs();
    a   = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReq, FwdA, FwdB};
    a_s = {StallF_s, StallD_s, StallE_s, StallM_s, FlushD_s, FlushE_s, FlushW_s, MemReq_s, FwdA_s, FwdB_s};
    checks = checks + 4;
    if (a !== e) begin
      errors++;
      $display("FAIL outs t=%0t actual=%b required=%b", $time, a, e);
    end
    if (a_s !== e) begin
      errors++;
      $display("FAIL outs_small t=%0t actual=%b required=%b", $time, a_s, e);
    end
    if ({MemErr, MemErr_s} !== {m_err, m_err}) begin
      errors++;
      $display("FAIL mem_err t=%0t actual=%b%b required=%b", $time, MemErr, MemErr_s, m_err);
    end
    if (int'(Count) != m_cnt || int'(Count_s) != m_cnt_s || $isunknown({Count, Count_s})) begin
      errors++;
      $display("FAIL stall_count t=%0t actual=%0d/%0d required=%0d/%0d", $time, Count, Count_s, m_cnt, m_cnt_s);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemAccessM = 0; MemReadyM = 1;
  endtask

  task automatic mid();
    @(posedge clk); #1;
  endtask

  task automatic adv();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    MemAccessM = 1; RdM = 3; Rs1E = 3; RegWriteM = 1; PCSrcE = 1;
    mid();
    chk("reset_stallf", StallF, 0);
    chk("reset_flushes", {FlushD, FlushE, FlushW}, 7);
    chk("reset_memreq", MemReq, 0);
    chk("reset_fwd_a", FwdA, 0);
    chk("reset_count", Count, 0);
    adv();
    rst_n = 1;
    idle();

    // load-use on x5 via rs1, then released
    ResultSrcE = 1; RdE = 5; Rs1D = 5;
    mid();
    chk("lu_stall", {StallF, StallD, FlushE, FlushD, StallE}, 5'b11100);
    adv();
    ResultSrcE = 0;
    mid();
    chk("lu_released", {StallF, StallD, FlushE}, 0);
    adv();
    // load-use via rs2, and the x0 case
    ResultSrcE = 1; RdE = 9; Rs1D = 1; Rs2D = 9;
    mid(); chk("lu_rs2", StallF, 1); adv();
    RdE = 0; Rs1D = 0; Rs2D = 0;
    mid(); chk("lu_x0", {StallF, FlushE}, 0); adv();
    // branch beats load-use
    RdE = 5; Rs1D = 5; PCSrcE = 1;
    mid(); chk("branch_prio", {FlushD, FlushE, StallF, StallD}, 4'b1100); adv();
    idle();
    mid(); chk("count_after_lu", Count, 2); adv();

    // forwarding priority
    RdM = 7; RdW = 7; Rs1E = 7; RegWriteM = 1; RegWriteW = 1; Rs2E = 9;
    mid(); chk("fwd_a_mem", FwdA, 2); chk("fwd_b_none", FwdB, 0); adv();
    RegWriteM = 0;
    mid(); chk("fwd_a_wb", FwdA, 1); adv();
    RdW = 0; Rs1E = 0;
    mid(); chk("fwd_a_x0", FwdA, 0); adv();
    idle();

    // zero-cost access
    MemAccessM = 1; MemReadyM = 1;
    mid(); chk("mem_fast", {StallF, MemReq}, 2'b01); adv();

    // three stall cycles, hazards during the stall are ignored
    MemReadyM = 0;
    for (int i = 1; i <= 4; i++) begin
      ResultSrcE = (i == 2); RdE = 4; Rs1D = 4; PCSrcE = (i == 2);
      if (i == 4) begin ResultSrcE = 0; PCSrcE = 0; MemReadyM = 1; end
      mid();
      if (i < 4) chk("memwait_stall", {StallF, StallM, FlushW, FlushD, FlushE, MemReq}, 6'b111001);
      else chk("memwait_done", {StallF, FlushW, MemReq}, 3'b001);
      adv();
    end
    idle();
    mid(); chk("count_after_wait", Count, 5); adv();

    // ready on the last permitted wait cycle wins
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 1; i <= MAXW + 1; i++) begin
      if (i == MAXW + 1) MemReadyM = 1;
      mid(); adv();
    end
    idle();
    mid(); chk("late_ready_no_err", MemErr, 0); chk("count_after_late", Count, 13); adv();

    // timeout
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 1; i <= MAXW + 4; i++) begin
      if (i == MAXW + 3) MemReadyM = 1;
      mid();
      if (i == MAXW + 1) chk("err_not_yet", MemErr, 0);
      if (i == MAXW + 2) chk("err_set", {MemErr, StallF, StallM, FlushW, MemReq}, 5'b11110);
      if (i == MAXW + 4) chk("err_sticky", MemErr, 1);
      adv();
    end
    mid();
    chk("count_err", Count, 13 + MAXW + 4);
    chk("count_sat", Count_s, 15);
    rst_n = 0;
    #1;
    chk("rst_err", MemErr, 0);
    chk("rst_count", Count, 0);
    chk("rst_outs", {StallF, FlushD, FlushE, FlushW, MemReq}, 5'b01110);
    adv();
    rst_n = 1;
    idle();
    mid(); chk("post_rst", {StallF, MemErr, Count[3:0]}, 0); adv();
    MemAccessM = 1; MemReadyM = 1;
    mid(); chk("post_rst_req", MemReq, 1); adv();
    idle();
    mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencing controller for the five-stage RISC-V core. It drives the stall and flush enables of the fetch/decode/execute/memory pipeline registers, selects the execute-stage forwarding paths, and runs a wait-state FSM for multi-cycle data-memory accesses with a timeout error. It sits beside the datapath and has no data path of its own beyond register-address compares and counters.

## Interface
- `REGISTER_ADDRESS_WIDTH`, 5: register index width.
- `MAX_MEM_WAIT`, 8: maximum number of MEM_WAIT cycles before a timeout error; must be ≥ 2.
- `STALL_CNT_WIDTH`, 16: width of the stall performance counter.

Ports:
- `clk`, in, 1: clock. All flops update on the falling edge, the same edge as the pipeline registers.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `Rs1D_i`, `Rs2D_i`, in, RAW: source registers of the instruction in decode.
- `Rs1E_i`, `Rs2E_i`, `RdE_i`, in, RAW: source and destination registers of the instruction in execute.
- `ResultSrcE_i`, in, 1: the instruction in execute is a load.
- `PCSrcE_i`, in, 1: a branch or jump is taken in execute.
- `RdM_i`, in, RAW; `RegWriteM_i`, in, 1: destination register and write enable of the instruction in memory.
- `RdW_i`, in, RAW; `RegWriteW_i`, in, 1: destination register and write enable of the instruction in writeback.
- `MemAccessM_i`, in, 1: the memory stage holds a load or store.
- `MemReadyM_i`, in, 1: data-memory acknowledge.
- `StallF_o`, `StallD_o`, `StallE_o`, `StallM_o`, out, 1 each: hold the corresponding pipeline register.
- `FlushD_o`, `FlushE_o`, `FlushW_o`, out, 1 each: load a bubble into that stage's register.
- `ForwardAE_o`, `ForwardBE_o`, out, 2 each: operand select. 00 selects the register file, 01 selects the writeback result, 10 selects the memory-stage ALU result.
- `MemReqM_o`, out, 1: data-memory request.
- `MemErr_o`, out, 1: sticky timeout error.
- `StallCount_o`, out, STALL_CNT_WIDTH: saturating stall counter.

RAW = REGISTER_ADDRESS_WIDTH.

## Operation
**FSM states:** RUN, MEM_WAIT, ERROR.

**RUN**
- `MemReqM_o` = `MemAccessM_i`.
- If `MemAccessM_i` is high and `MemReadyM_i` is low:
  - memory stall this cycle: all four stalls = 1, `FlushW_o` = 1, no D/E flush;
  - transition to MEM_WAIT, and the wait counter loads 1.
- Otherwise, apply the hazard rules below.

**MEM_WAIT**
- `MemReqM_o` = 1. Memory stall outputs are driven as in RUN.
- `MemReadyM_i` = 1: no memory stall this cycle, the stage completes, and the hazard rules apply. Return to RUN.
- Otherwise the wait counter increments. When the counter equals MAX_MEM_WAIT and `MemReadyM_i` is still 0, transition to ERROR.

**ERROR**
- All stalls = 1, `FlushW_o` = 1, `MemReqM_o` = 0, `MemErr_o` = 1.
- Left only by reset.

**Hazard rules** (apply only in non-memory-stall cycles)
- Load-use hazard: `ResultSrcE_i` && `RdE_i` ≠ 0 && (`RdE_i` == `Rs1D_i` || `RdE_i` == `Rs2D_i`).
- Taken branch (`PCSrcE_i` = 1): `FlushD_o` = `FlushE_o` = 1. `StallF_o`/`StallD_o` = 0, even if a load-use hazard is present, so the branch has priority.
- Load-use hazard without a taken branch: `StallF_o` = `StallD_o` = 1 and `FlushE_o` = 1 for exactly one cycle.

**Forwarding** (computed every cycle, independent of FSM state)
- `ForwardAE_o` = 10 if `RegWriteM_i` && `RdM_i` ≠ 0 && `RdM_i` == `Rs1E_i`.
- Else 01 if `RegWriteW_i` && `RdW_i` ≠ 0 && `RdW_i` == `Rs1E_i`.
- Else 00.
- Memory stage has priority over writeback. `ForwardBE_o` is identical, using `Rs2E_i`.

**Stall counter:** increments on each edge where `StallF_o` = 1 and saturates at all-ones.

## Timing
- Stall, flush, forward and `MemReqM_o` outputs are combinational from the current state and inputs. They must settle before the next falling edge.
- FSM state, wait counter and `StallCount_o` are registered on the falling edge.
- **Reset values:**
  - state RUN, wait counter 0, `MemErr_o` 0, `StallCount_o` 0;
  - while `rst_n` = 0: all stalls 0, `FlushD_o`/`FlushE_o`/`FlushW_o` = 1, `MemReqM_o` = 0, forwards 00.
- A memory access acknowledged in its first cycle costs 0 stall cycles. Ready on the Nth MEM_WAIT cycle costs N stall cycles.
- Timeout: ERROR is entered on the edge ending MEM_WAIT cycle MAX_MEM_WAIT without ready. Ready arriving in that same cycle wins, and the FSM returns to RUN.
- A load-use hazard or taken branch coinciding with a memory stall is ignored for that cycle. It re-evaluates once the pipeline is released.
- Asserting `rst_n` low mid-MEM_WAIT or in ERROR returns the FSM to RUN immediately (asynchronously).

## Structure
- Shared package `hazard_pkg`:
  - state enum {RUN, MEM_WAIT, ERROR};
  - forward-select localparams FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module is natural: `forward_unit`, a pure combinational compare for one operand, instantiated twice (A and B).

## Test plan
- **Load-use:** E = load to x5, D reads x5 → `StallF_o`/`StallD_o`/`FlushE_o` = 1 for 1 cycle, then 0. Repeat with x0 → no stall.
- **Branch vs load-use:** `PCSrcE_i` = 1 together with a load-use hazard → `FlushD_o` = `FlushE_o` = 1, `StallF_o` = 0.
- **Forward priority:** `RdM_i` = `RdW_i` = `Rs1E_i` = 7, both write enables high → `ForwardAE_o` = 10. Clear `RegWriteM_i` → 01. `Rs2E_i` unmatched → `ForwardBE_o` = 00.
- **Memory wait:** `MemAccessM_i` = 1, ready low for 3 cycles then high → 3 full-stall cycles with `FlushW_o` = 1, FSM back to RUN, `StallCount_o` += 3.
- **Timeout:** ready never asserted, MAX_MEM_WAIT = 8 → `MemErr_o` rises after the 8th wait cycle and stalls hold. Pulse `rst_n` low → all registered state returns to reset values.
- **Counter saturation:** STALL_CNT_WIDTH = 4 with 20 stall cycles → `StallCount_o` = 15.
